multicore_exec_unit: RTL and testbench
======================================

Name: multicore_exec_unit

Overview:
- Parametrised successor to the nine-core execute block.
- Executes one instruction at a time on behalf of NUM_CORES logical cores. Each core has a private register file, stack and halt flag; data memory is shared.
- Adds a valid/ready input handshake, a registered result with status, iterative divide, per-core stacks with overflow/underflow reporting, and per-core halt/resume.
- Sits between the instruction dispatcher and the core scheduler.

Parameters:
- NUM_CORES, 8, number of logical cores; core_id width CID_W = clog2(NUM_CORES), min 1.
- DATA_W, 8, register, operand, memory and result width.
- NUM_REGS, 4, registers per core; power of two; index = low clog2(NUM_REGS) bits of operand.
- STACK_DEPTH, 16, entries per core stack.
- MEM_DEPTH, 256, shared memory words; power of two; address = low clog2(MEM_DEPTH) bits of operand2.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- in_valid  in  1  instruction present.
- in_ready  out  1  unit can accept an instruction.
- in_core  in  CID_W  target core.
- in_opcode  in  8  opcode.
- in_op1  in  DATA_W  operand1.
- in_op2  in  DATA_W  operand2.
- out_valid  out  1  one-cycle completion pulse; no backpressure.
- out_core  out  CID_W  core of the completed instruction.
- out_result  out  DATA_W  result value.
- out_status  out  3  0 OK, 1 STK_OVF, 2 STK_UNF, 3 DIV_ZERO, 4 ILLEGAL, 5 HALTED.

Behaviour:
- Reset (asynchronous): in_ready=1, out_valid=0, out_core=0, out_result=0, out_status=0, FSM=IDLE. All registers, stack pointers and halt flags clear to 0. Memory and stack contents are not reset.
- Accept: an instruction is accepted when in_valid && in_ready. in_ready=1 in IDLE and 0 in DIV.
- FSM states: IDLE, DIV.
  - In IDLE, every non-divide opcode completes in one cycle. Accepted at edge T, out_valid=1 during cycle T+1, and a new accept is possible at T+1 (throughput 1 per cycle).
  - DIV/MOD with a nonzero divisor moves IDLE->DIV.
- Opcodes (rA = reg[op1], rB = reg[op2]):
  - 00 MOV: rA=op2.
  - 01 ADD, 02 SUB, 03 MUL: rA op rB, truncated to DATA_W.
  - 04 DIV, 05 MOD.
  - 06 AND, 07 OR, 08 XOR: rA op rB.
  - 09 NOT: rA=~rA.
  - 0A SHL, 0B SHR: shift rA by op2; shift amount >= DATA_W yields 0.
  - 0C PUSH: push rA.
  - 0D POP: pop into rA.
  - 0E JMP: result=op1.
  - 0F JZ, 10 JNZ: test reg[0]; result=op1 if taken, else 0.
  - 11 CMP: reg[2 mod NUM_REGS] = (rA==rB).
  - 12 CALL: push op1.
  - 13 RET: pop to result.
  - 14 HLT: set the halt flag; result=all-ones.
  - 15 NOP.
  - 16 LOAD: rA=mem[op2].
  - 17 STORE: mem[op2]=rA.
  - 18 RESUME: clear the halt flag of core op1.
- out_result: the new destination register value for register-writing ops; the stored value for STORE; 0 for NOP.
- Stack: sp counts entries.
  - PUSH/CALL with sp==STACK_DEPTH: no write, STK_OVF.
  - POP/RET with sp==0: no change, result 0, STK_UNF.
  - Push writes stack[sp] then sp+1; pop reads stack[sp-1] then sp-1.
- Halted core: every opcode except 18 completes with status HALTED and no state change.
- Illegal: unknown opcode, or in_core >= NUM_CORES, gives status ILLEGAL and no state change. RESUME with op1 >= NUM_CORES is also ILLEGAL.
- Divide:
  - Divisor rB==0: completes in 1 cycle; rA unchanged; result all-ones; DIV_ZERO.
  - Otherwise: restoring divider, one quotient bit per cycle, DATA_W cycles in DIV. out_valid lands DATA_W+1 cycles after accept, and in_ready returns to 1 in that same cycle.
  - Operands are latched at accept. DIV writes the quotient; MOD writes the remainder.
- Reset mid-divide: aborts; no out_valid is produced.
- Register hazards: an instruction sees all earlier writes, including a write completing in the accept cycle, because writes happen at the accept edge and out_result is registered.

Optional Feature:
- Macro: MCEU_HW_DIV_EN.
- Defined: iterative divider as specified above.
- Undefined: no divider logic; opcodes 04/05 complete in 1 cycle with status ILLEGAL and no state change; in_ready is constant 1 outside reset.

Test Plan:
- MOV core3 r1=0x2A, then ADD r1,r1 -> out_valid at T+1 with result 0x2A, then 0x54 on back-to-back cycles; core0 r1 stays 0.
- DIV with r0=200, r1=7 (DATA_W=8) -> in_ready low for 8 cycles; out_valid at T+9, result 28. MOD under the same conditions -> result 4.
- DIV with r1=0 -> 1-cycle completion, result 0xFF, status 3, r0 unchanged.
- 16 PUSHes then a 17th on core5 -> 17th status 1. Then 16 POPs return values in LIFO order, and a 17th POP gives status 2, result 0.
- HLT core2 -> result 0xFF. Next ADD on core2 -> status 5. RESUME op1=2 -> OK, and the following ADD executes.
- Assert reset during DIV cycle 4 -> no out_valid; in_ready=1; registers=0. A new MOV completes normally.

Source files
------------

// File: rtl/multicore_exec_unit_if.sv
// Instruction/result bus between the dispatcher (master) and multicore_exec_unit (slave).
interface multicore_exec_unit_if #(
  parameter int unsigned NUM_CORES = 8,
  parameter int unsigned DATA_W    = 8
);
  localparam int unsigned CID_W = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;

  logic              in_valid;
  logic              in_ready;
  logic [CID_W-1:0]  in_core;
  logic [7:0]        in_opcode;
  logic [DATA_W-1:0] in_op1;
  logic [DATA_W-1:0] in_op2;
  logic              out_valid;
  logic [CID_W-1:0]  out_core;
  logic [DATA_W-1:0] out_result;
  logic [2:0]        out_status;

  modport master (
    output in_valid, in_core, in_opcode, in_op1, in_op2,
    input  in_ready, out_valid, out_core, out_result, out_status
  );

  modport slave (
    input  in_valid, in_core, in_opcode, in_op1, in_op2,
    output in_ready, out_valid, out_core, out_result, out_status
  );
endinterface

// File: rtl/multicore_exec_unit.sv
// Execute unit serving NUM_CORES logical cores (private regs/stack/halt, shared memory).
// Define MCEU_HW_DIV_EN to build the iterative restoring divider for DIV/MOD.
module multicore_exec_unit #(
  parameter int unsigned NUM_CORES   = 8,
  parameter int unsigned DATA_W      = 8,
  parameter int unsigned NUM_REGS    = 4,
  parameter int unsigned STACK_DEPTH = 16,
  parameter int unsigned MEM_DEPTH   = 256
) (
  input logic                  clk,
  input logic                  reset,
  multicore_exec_unit_if.slave bus
);
  localparam int unsigned CID_W = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;
  localparam int unsigned RI_W  = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
  localparam int unsigned SI_W  = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;
  localparam int unsigned SP_W  = $clog2(STACK_DEPTH + 1);
  localparam int unsigned MA_W  = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;

  localparam logic [7:0] OP_MOV    = 8'h00;
  localparam logic [7:0] OP_ADD    = 8'h01;
  localparam logic [7:0] OP_SUB    = 8'h02;
  localparam logic [7:0] OP_MUL    = 8'h03;
  localparam logic [7:0] OP_DIV    = 8'h04;
  localparam logic [7:0] OP_MOD    = 8'h05;
  localparam logic [7:0] OP_AND    = 8'h06;
  localparam logic [7:0] OP_OR     = 8'h07;
  localparam logic [7:0] OP_XOR    = 8'h08;
  localparam logic [7:0] OP_NOT    = 8'h09;
  localparam logic [7:0] OP_SHL    = 8'h0A;
  localparam logic [7:0] OP_SHR    = 8'h0B;
  localparam logic [7:0] OP_PUSH   = 8'h0C;
  localparam logic [7:0] OP_POP    = 8'h0D;
  localparam logic [7:0] OP_JMP    = 8'h0E;
  localparam logic [7:0] OP_JZ     = 8'h0F;
  localparam logic [7:0] OP_JNZ    = 8'h10;
  localparam logic [7:0] OP_CMP    = 8'h11;
  localparam logic [7:0] OP_CALL   = 8'h12;
  localparam logic [7:0] OP_RET    = 8'h13;
  localparam logic [7:0] OP_HLT    = 8'h14;
  localparam logic [7:0] OP_NOP    = 8'h15;
  localparam logic [7:0] OP_LOAD   = 8'h16;
  localparam logic [7:0] OP_STORE  = 8'h17;
  localparam logic [7:0] OP_RESUME = 8'h18;

  localparam logic [2:0] ST_OK       = 3'd0;
  localparam logic [2:0] ST_STK_OVF  = 3'd1;
  localparam logic [2:0] ST_STK_UNF  = 3'd2;
  localparam logic [2:0] ST_DIV_ZERO = 3'd3;
  localparam logic [2:0] ST_ILLEGAL  = 3'd4;
  localparam logic [2:0] ST_HALTED   = 3'd5;

  typedef enum logic {S_IDLE, S_DIV} state_t;

  state_t state, state_nx;

  logic              ready_q;
  logic              out_valid_q;
  logic [CID_W-1:0]  out_core_q;
  logic [DATA_W-1:0] out_result_q;
  logic [2:0]        out_status_q;

  logic [DATA_W-1:0] regs  [NUM_CORES][NUM_REGS];
  logic [DATA_W-1:0] stack [NUM_CORES][STACK_DEPTH];
  logic [DATA_W-1:0] mem   [MEM_DEPTH];
  logic [SP_W-1:0]   sp    [NUM_CORES];
  logic [NUM_CORES-1:0] halted;

  // Decoded view of the incoming instruction
  logic              core_ok;
  logic [CID_W-1:0]  cix;
  logic [RI_W-1:0]   ia, ib;
  logic [DATA_W-1:0] ra, rb;
  logic [SP_W-1:0]   sp_cur;
  logic [MA_W-1:0]   mem_addr;

  assign core_ok  = 32'(bus.in_core) < NUM_CORES;
  assign cix      = core_ok ? bus.in_core : '0;
  assign ia       = RI_W'(bus.in_op1);
  assign ib       = RI_W'(bus.in_op2);
  assign ra       = regs[cix][ia];
  assign rb       = regs[cix][ib];
  assign sp_cur   = sp[cix];
  assign mem_addr = MA_W'(bus.in_op2);

  logic              valid_nx;
  logic [CID_W-1:0]  core_nx;
  logic [DATA_W-1:0] result_nx;
  logic [2:0]        status_nx;
  logic              reg_we;
  logic [CID_W-1:0]  reg_wcore;
  logic [RI_W-1:0]   reg_widx;
  logic [DATA_W-1:0] reg_wdata;
  logic              stk_we;
  logic [SI_W-1:0]   stk_idx;
  logic [DATA_W-1:0] stk_wdata;
  logic              sp_we;
  logic [SP_W-1:0]   sp_wdata;
  logic              halt_set, halt_clr;
  logic [CID_W-1:0]  halt_core;
  logic              mem_we;
  logic [DATA_W-1:0] pop_val;
  logic              div_start;

`ifdef MCEU_HW_DIV_EN
  localparam int unsigned CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

  logic [DATA_W-1:0] div_quo, div_rem, div_den;
  logic [CNT_W-1:0]  div_cnt;
  logic [CID_W-1:0]  div_core;
  logic [RI_W-1:0]   div_idx;
  logic              div_mod;
  logic [DATA_W:0]   rem_sh;
  logic [DATA_W-1:0] quo_step, rem_step;

  // One restoring-division step: shift in the next dividend bit, subtract if it fits
  always_comb begin
    rem_sh   = {div_rem, div_quo[DATA_W-1]};
    rem_step = DATA_W'(rem_sh);
    quo_step = DATA_W'({div_quo, 1'b0});
    if (rem_sh >= {1'b0, div_den}) begin
      rem_step = DATA_W'(rem_sh - {1'b0, div_den});
      quo_step = DATA_W'({div_quo, 1'b1});
    end
  end
`endif

  // Next-state, datapath write controls and registered-output next values
  always_comb begin
    state_nx  = state;
    valid_nx  = 1'b0;
    core_nx   = out_core_q;
    result_nx = out_result_q;
    status_nx = out_status_q;
    reg_we    = 1'b0;
    reg_wcore = cix;
    reg_widx  = ia;
    reg_wdata = '0;
    stk_we    = 1'b0;
    stk_idx   = SI_W'(sp_cur);
    stk_wdata = ra;
    sp_we     = 1'b0;
    sp_wdata  = sp_cur;
    halt_set  = 1'b0;
    halt_clr  = 1'b0;
    halt_core = CID_W'(bus.in_op1);
    mem_we    = 1'b0;
    div_start = 1'b0;
    pop_val   = stack[cix][SI_W'(sp_cur - SP_W'(1))];

    case (state)
      S_IDLE: begin
        if (bus.in_valid) begin
          valid_nx  = 1'b1;
          core_nx   = bus.in_core;
          result_nx = '0;
          status_nx = ST_OK;
          if (!core_ok) begin
            status_nx = ST_ILLEGAL;
          end else if (halted[cix] && bus.in_opcode != OP_RESUME) begin
            status_nx = ST_HALTED;
          end else begin
            case (bus.in_opcode)
              OP_MOV: begin reg_we = 1'b1; reg_wdata = bus.in_op2; end
              OP_ADD: begin reg_we = 1'b1; reg_wdata = ra + rb; end
              OP_SUB: begin reg_we = 1'b1; reg_wdata = ra - rb; end
              OP_MUL: begin reg_we = 1'b1; reg_wdata = ra * rb; end
`ifdef MCEU_HW_DIV_EN
              OP_DIV, OP_MOD: begin
                if (rb == '0) begin
                  result_nx = '1;
                  status_nx = ST_DIV_ZERO;
                end else begin
                  valid_nx  = 1'b0;
                  div_start = 1'b1;
                  state_nx  = S_DIV;
                end
              end
`endif
              OP_AND: begin reg_we = 1'b1; reg_wdata = ra & rb; end
              OP_OR:  begin reg_we = 1'b1; reg_wdata = ra | rb; end
              OP_XOR: begin reg_we = 1'b1; reg_wdata = ra ^ rb; end
              OP_NOT: begin reg_we = 1'b1; reg_wdata = ~ra; end
              OP_SHL: begin
                reg_we    = 1'b1;
                reg_wdata = (32'(bus.in_op2) >= DATA_W) ? '0 : ra << bus.in_op2;
              end
              OP_SHR: begin
                reg_we    = 1'b1;
                reg_wdata = (32'(bus.in_op2) >= DATA_W) ? '0 : ra >> bus.in_op2;
              end
              OP_PUSH, OP_CALL: begin
                stk_wdata = (bus.in_opcode == OP_CALL) ? bus.in_op1 : ra;
                if (32'(sp_cur) == STACK_DEPTH) begin
                  status_nx = ST_STK_OVF;
                end else begin
                  stk_we    = 1'b1;
                  sp_we     = 1'b1;
                  sp_wdata  = sp_cur + SP_W'(1);
                  result_nx = stk_wdata;
                end
              end
              OP_POP, OP_RET: begin
                if (sp_cur == '0) begin
                  status_nx = ST_STK_UNF;
                end else begin
                  sp_we     = 1'b1;
                  sp_wdata  = sp_cur - SP_W'(1);
                  result_nx = pop_val;
                  reg_we    = (bus.in_opcode == OP_POP);
                  reg_wdata = pop_val;
                end
              end
              OP_JMP: result_nx = bus.in_op1;
              OP_JZ:  result_nx = (regs[cix][0] == '0) ? bus.in_op1 : '0;
              OP_JNZ: result_nx = (regs[cix][0] != '0) ? bus.in_op1 : '0;
              OP_CMP: begin
                reg_we    = 1'b1;
                reg_widx  = RI_W'(2 % NUM_REGS);
                reg_wdata = DATA_W'(ra == rb);
              end
              OP_HLT: begin halt_set = 1'b1; result_nx = '1; end
              OP_NOP: result_nx = '0;
              OP_LOAD: begin reg_we = 1'b1; reg_wdata = mem[mem_addr]; end
              OP_STORE: begin mem_we = 1'b1; result_nx = ra; end
              OP_RESUME: begin
                if (32'(bus.in_op1) >= NUM_CORES) status_nx = ST_ILLEGAL;
                else                             halt_clr  = 1'b1;
              end
              default: status_nx = ST_ILLEGAL;
            endcase
          end
        end
      end
      S_DIV: begin
`ifdef MCEU_HW_DIV_EN
        // Last quotient bit resolves this cycle: write back and report
        if (div_cnt == CNT_W'(DATA_W - 1)) begin
          state_nx  = S_IDLE;
          valid_nx  = 1'b1;
          core_nx   = div_core;
          status_nx = ST_OK;
          reg_we    = 1'b1;
          reg_wcore = div_core;
          reg_widx  = div_idx;
          reg_wdata = div_mod ? rem_step : quo_step;
        end
`else
        state_nx = S_IDLE;
`endif
      end
    endcase

    if (reg_we) result_nx = reg_wdata;
  end

  // Control, outputs and per-core architectural state
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= S_IDLE;
      ready_q      <= 1'b1;
      out_valid_q  <= 1'b0;
      out_core_q   <= '0;
      out_result_q <= '0;
      out_status_q <= ST_OK;
      halted       <= '0;
      for (int c = 0; c < NUM_CORES; c++) begin
        sp[c] <= '0;
        for (int r = 0; r < NUM_REGS; r++) regs[c][r] <= '0;
      end
    end else begin
      state        <= state_nx;
      ready_q      <= (state_nx == S_IDLE);
      out_valid_q  <= valid_nx;
      out_core_q   <= core_nx;
      out_result_q <= result_nx;
      out_status_q <= status_nx;
      if (reg_we)   regs[reg_wcore][reg_widx] <= reg_wdata;
      if (sp_we)    sp[cix] <= sp_wdata;
      if (halt_set) halted[cix] <= 1'b1;
      if (halt_clr) halted[halt_core] <= 1'b0;
    end
  end

  // Stack and shared memory contents survive reset
  always_ff @(posedge clk) begin
    if (stk_we) stack[cix][stk_idx] <= stk_wdata;
    if (mem_we) mem[mem_addr] <= ra;
  end

`ifdef MCEU_HW_DIV_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      div_quo  <= '0;
      div_rem  <= '0;
      div_den  <= '0;
      div_cnt  <= '0;
      div_core <= '0;
      div_idx  <= '0;
      div_mod  <= 1'b0;
    end else if (div_start) begin
      div_quo  <= ra;
      div_rem  <= '0;
      div_den  <= rb;
      div_cnt  <= '0;
      div_core <= cix;
      div_idx  <= ia;
      div_mod  <= (bus.in_opcode == OP_MOD);
    end else if (state == S_DIV) begin
      div_quo  <= quo_step;
      div_rem  <= rem_step;
      div_cnt  <= div_cnt + CNT_W'(1);
    end
  end
`endif

  assign bus.in_ready   = ready_q;
  assign bus.out_valid  = out_valid_q;
  assign bus.out_core   = out_core_q;
  assign bus.out_result = out_result_q;
  assign bus.out_status = out_status_q;

endmodule

// File: tb/tb_multicore_exec_unit.sv
// Randomized bench for multicore_exec_unit against a queue/array reference model.
module tb_multicore_exec_unit;
  localparam int NC   = 8;
  localparam int DW   = 8;
  localparam int NR   = 4;
  localparam int SD   = 16;
  localparam int MD   = 256;
  localparam int CW   = 3;
  localparam int MASK = (1 << DW) - 1;

  logic clk = 1'b0;
  logic reset = 1'b1;

  multicore_exec_unit_if #(.NUM_CORES(NC), .DATA_W(DW)) bus ();

  multicore_exec_unit #(
    .NUM_CORES(NC), .DATA_W(DW), .NUM_REGS(NR), .STACK_DEPTH(SD), .MEM_DEPTH(MD)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  int m_reg [NC][NR];
  int m_stk [NC][$];
  bit m_halt[NC];
  int m_mem [MD];

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s got=%0d expected=%0d at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic void model_reset();
    for (int c = 0; c < NC; c++) begin
      m_halt[c] = 1'b0;
      m_stk[c].delete();
      for (int r = 0; r < NR; r++) m_reg[c][r] = 0;
    end
  endfunction

  // Architectural effect of one instruction: expected result, status and latency
  function automatic void model(input int c, input int op, input int a, input int b,
                                output int res, output int st, output int lat);
    int ia, ib, ra, rb;
    ia = a % NR;
    ib = b % NR;
    res = 0; st = 0; lat = 1;
    if (c >= NC) begin st = 4; return; end
    ra = m_reg[c][ia];
    rb = m_reg[c][ib];
    if (m_halt[c] && op != 'h18) begin st = 5; return; end
    case (op)
      'h00: begin m_reg[c][ia] = b; res = b; end
      'h01: begin m_reg[c][ia] = (ra + rb) & MASK; res = m_reg[c][ia]; end
      'h02: begin m_reg[c][ia] = (ra - rb) & MASK; res = m_reg[c][ia]; end
      'h03: begin m_reg[c][ia] = (ra * rb) & MASK; res = m_reg[c][ia]; end
`ifdef MCEU_HW_DIV_EN
      'h04, 'h05: begin
        if (rb == 0) begin res = MASK; st = 3; end
        else begin
          m_reg[c][ia] = (op == 'h04) ? ra / rb : ra % rb;
          res = m_reg[c][ia];
          lat = DW + 1;
        end
      end
`endif
      'h06: begin m_reg[c][ia] = ra & rb; res = m_reg[c][ia]; end
      'h07: begin m_reg[c][ia] = ra | rb; res = m_reg[c][ia]; end
      'h08: begin m_reg[c][ia] = ra ^ rb; res = m_reg[c][ia]; end
      'h09: begin m_reg[c][ia] = ~ra & MASK; res = m_reg[c][ia]; end
      'h0A: begin m_reg[c][ia] = (b >= DW) ? 0 : (ra << b) & MASK; res = m_reg[c][ia]; end
      'h0B: begin m_reg[c][ia] = (b >= DW) ? 0 : ra >> b; res = m_reg[c][ia]; end
      'h0C, 'h12: begin
        if (m_stk[c].size() == SD) st = 1;
        else begin
          res = (op == 'h12) ? a : ra;
          m_stk[c].push_back(res);
        end
      end
      'h0D, 'h13: begin
        if (m_stk[c].size() == 0) st = 2;
        else begin
          res = m_stk[c].pop_back();
          if (op == 'h0D) m_reg[c][ia] = res;
        end
      end
      'h0E: res = a;
      'h0F: res = (m_reg[c][0] == 0) ? a : 0;
      'h10: res = (m_reg[c][0] != 0) ? a : 0;
      'h11: begin m_reg[c][2 % NR] = (ra == rb) ? 1 : 0; res = m_reg[c][2 % NR]; end
      'h14: begin m_halt[c] = 1'b1; res = MASK; end
      'h15: res = 0;
      'h16: begin m_reg[c][ia] = m_mem[b % MD]; res = m_reg[c][ia]; end
      'h17: begin m_mem[b % MD] = ra; res = ra; end
      'h18: begin
        if (a >= NC) st = 4;
        else m_halt[a] = 1'b0;
      end
      default: st = 4;
    endcase
  endfunction

  // Issue at a negedge with the unit idle; returns at the negedge where the result is visible
  task automatic exec(input int c, input int op, input int a, input int b);
    int res, st, lat;
    model(c, op, a & MASK, b & MASK, res, st, lat);
    check("in_ready_idle", int'(bus.in_ready), 1);
    bus.in_valid  = 1'b1;
    bus.in_core   = CW'(c);
    bus.in_opcode = 8'(op);
    bus.in_op1    = DW'(a);
    bus.in_op2    = DW'(b);
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
    for (int i = 0; i < lat - 1; i++) begin
      check("busy_ready", int'(bus.in_ready), 0);
      check("busy_valid", int'(bus.out_valid), 0);
      @(negedge clk);
    end
    check("out_valid", int'(bus.out_valid), 1);
    check("out_core", int'(bus.out_core), c);
    check("out_result", int'(bus.out_result), res);
    check("out_status", int'(bus.out_status), st);
    if (lat > 1) check("ready_back", int'(bus.in_ready), 1);
  endtask

  task automatic idle_check();
    @(negedge clk);
    check("idle_valid", int'(bus.out_valid), 0);
  endtask

  initial begin
    int c, op, a, b;
    bus.in_valid  = 1'b0;
    bus.in_core   = '0;
    bus.in_opcode = '0;
    bus.in_op1    = '0;
    bus.in_op2    = '0;
    model_reset();

    @(negedge clk);
    check("rst_ready", int'(bus.in_ready), 1);
    check("rst_valid", int'(bus.out_valid), 0);
    check("rst_core", int'(bus.out_core), 0);
    check("rst_result", int'(bus.out_result), 0);
    check("rst_status", int'(bus.out_status), 0);
    reset = 1'b0;

    // Back-to-back MOV/ADD on core3, core0 untouched
    exec(3, 'h00, 1, 'h2A);
    exec(3, 'h01, 1, 1);
    exec(0, 'h07, 1, 1);
    idle_check();

    // Divide and modulo, plus divide by zero
    exec(1, 'h00, 0, 200);
    exec(1, 'h00, 1, 7);
    exec(1, 'h04, 0, 1);
    exec(1, 'h00, 0, 200);
    exec(1, 'h05, 0, 1);
    exec(1, 'h00, 0, 200);
    exec(1, 'h00, 1, 0);
    exec(1, 'h04, 0, 1);
    exec(1, 'h07, 0, 0);

    // Stack overflow / LIFO / underflow on core5
    for (int i = 0; i < SD; i++) begin
      exec(5, 'h00, 0, 3 * i + 1);
      exec(5, 'h0C, 0, 0);
    end
    exec(5, 'h00, 0, 99);
    exec(5, 'h0C, 0, 0);
    for (int i = 0; i <= SD; i++) exec(5, 'h0D, 1, 0);
    exec(5, 'h12, 77, 0);
    exec(5, 'h13, 0, 0);

    // Halt and resume
    exec(2, 'h00, 1, 5);
    exec(2, 'h14, 0, 0);
    exec(2, 'h01, 1, 1);
    exec(0, 'h18, 2, 0);
    exec(2, 'h01, 1, 1);
    exec(0, 'h18, 9, 0);
    exec(0, 'h40, 0, 0);
    exec(4, 'h0A, 0, 8);

    // Seed a small memory window so random LOADs read defined data
    for (int i = 0; i < 16; i++) begin
      exec(0, 'h00, 0, i * 7 + 3);
      exec(0, 'h17, 0, i);
    end

    for (int n = 0; n < 400; n++) begin
      c  = $urandom_range(0, NC - 1);
      op = $urandom_range(0, 25);
      a  = $urandom_range(0, 255);
      b  = $urandom_range(0, 255);
      if (op == 25) op = $urandom_range(25, 255);
      if (op == 'h14 && $urandom_range(0, 3) != 0) op = 'h15;
      if (op == 'h16 || op == 'h17) b = $urandom_range(0, 15);
      if (op == 'h0A || op == 'h0B) b = $urandom_range(0, 10);
      if (op == 'h18) a = $urandom_range(0, NC + 1);
      exec(c, op, a, b);
      if ($urandom_range(0, 7) == 0) idle_check();
    end

    // Reset in the middle of a divide (or mid-stream without the divider)
    exec(1, 'h00, 0, 200);
    exec(1, 'h00, 1, 7);
    exec(6, 'h00, 3, 9);
`ifdef MCEU_HW_DIV_EN
    bus.in_valid  = 1'b1;
    bus.in_core   = CW'(1);
    bus.in_opcode = 8'h04;
    bus.in_op1    = DW'(0);
    bus.in_op2    = DW'(1);
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
    repeat (3) @(negedge clk);
`endif
    reset = 1'b1;
    #1;
    check("midrst_valid", int'(bus.out_valid), 0);
    check("midrst_ready", int'(bus.in_ready), 1);
    check("midrst_result", int'(bus.out_result), 0);
    @(negedge clk);
    reset = 1'b0;
    model_reset();
    for (int i = 0; i < DW; i++) begin
      @(negedge clk);
      check("post_rst_valid", int'(bus.out_valid), 0);
    end
    exec(1, 'h07, 0, 0);
    exec(6, 'h07, 3, 3);
    exec(1, 'h00, 2, 'h11);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end
endmodule
